// File: rtl/modulo_ticker_pkg.sv
// Shared definitions for the modulo ticker: direction encodings and a ceil-log2 helper.
package modulo_ticker_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Number of bits needed to hold values 0..value-1 (minimum 1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned bits;
    v    = (value > 1) ? value - 1 : 1;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/modulo_ticker_shadow_reg.sv
// Shadow modulus register with pending flag and zero-load error pulse.
//   i_clk       : system clock
//   i_rst_n     : synchronous active-low reset
//   i_mod_val   : candidate modulus
//   i_mod_load  : strobe to capture i_mod_val
//   i_apply     : boundary (wrap/restart) where the counter consumes the modulus
//   o_shadow    : captured modulus
//   o_pending   : shadow holds a modulus not yet applied
//   o_err       : 1-cycle pulse after a rejected zero load
//   o_load_ok_c : combinational, this cycle carries an acceptable load
module modulo_shadow_reg
  import modulo_ticker_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_mod_val,
  input  logic             i_mod_load,
  input  logic             i_apply,
  output logic [WIDTH-1:0] o_shadow,
  output logic             o_pending,
  output logic             o_err,
  output logic             o_load_ok_c
);

  logic [WIDTH-1:0] r_shadow;
  logic             r_pending;
  logic             r_err;
  logic             w_load_ok;
  logic             w_load_zero;

  assign w_load_ok   = i_mod_load && (i_mod_val != '0);
  assign w_load_zero = i_mod_load && (i_mod_val == '0);

  // An apply consumes whatever is pending, including a load on the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_load_zero;
      if (w_load_ok) r_shadow <= i_mod_val;
      if (i_apply)        r_pending <= 1'b0;
      else if (w_load_ok) r_pending <= 1'b1;
    end
  end

  assign o_shadow    = r_shadow;
  assign o_pending   = r_pending;
  assign o_err       = r_err;
  assign o_load_ok_c = w_load_ok;

endmodule

// File: rtl/modulo_ticker.sv
// Runtime-programmable modulo counter with glitch-free modulus update on wrap/restart.
//   clk         : system clock
//   rst         : synchronous active-low reset
//   en          : advance one step
//   dir         : 0 up, 1 down
//   restart     : jump to start value, applying any pending modulus
//   mod_val     : new modulus
//   mod_load    : strobe capturing mod_val
//   count       : registered count
//   zero        : count == 0 (combinational)
//   tick        : registered pulse the cycle after a wrap
//   mod_pending : a loaded modulus awaits a boundary
//   mod_err     : registered pulse after a rejected zero load
module modulo_ticker
  import modulo_ticker_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MOD_DEFAULT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             restart,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             mod_load,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tick,
  output logic             mod_pending,
  output logic             mod_err
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_m;
  logic             r_tick;

  logic [WIDTH-1:0] w_m_last;
  logic             w_wrap;
  logic             w_step_wrap;
  logic             w_apply;
  logic [WIDTH-1:0] w_m_next;
  logic [WIDTH-1:0] w_m_next_last;
  logic [WIDTH-1:0] w_start;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_shadow;
  logic             w_pending;
  logic             w_err;
  logic             w_load_ok;

  modulo_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_mod_val   (mod_val),
    .i_mod_load  (mod_load),
    .i_apply     (w_apply),
    .o_shadow    (w_shadow),
    .o_pending   (w_pending),
    .o_err       (w_err),
    .o_load_ok_c (w_load_ok)
  );

  // Wrap detection uses the currently active modulus.
  assign w_m_last    = r_m - WIDTH'(1);
  assign w_wrap      = (dir == DIR_UP) ? (r_count == w_m_last) : (r_count == '0);
  assign w_step_wrap = en && w_wrap;
  assign w_apply     = restart || w_step_wrap;

  // Next modulus and count; a same-cycle load bypasses the shadow register.
  always_comb begin
    w_m_next     = r_m;
    w_count_next = r_count;
    if (w_apply) begin
      if (w_load_ok)      w_m_next = mod_val;
      else if (w_pending) w_m_next = w_shadow;
    end
    w_m_next_last = w_m_next - WIDTH'(1);
    w_start       = (dir == DIR_DOWN) ? w_m_next_last : '0;
    if (w_apply) begin
      w_count_next = w_start;
    end else if (en) begin
      w_count_next = (dir == DIR_UP) ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      r_m     <= WIDTH'(MOD_DEFAULT);
      r_tick  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_m     <= w_m_next;
      r_tick  <= w_step_wrap && !restart;
    end
  end

  assign count       = r_count;
  assign zero        = (r_count == '0);
  assign tick        = r_tick;
  assign mod_pending = w_pending;
  assign mod_err     = w_err;

endmodule

// File: tb/tb_modulo_ticker.sv
// Directed self-checking bench for modulo_ticker.
module tb_modulo_ticker;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             dir;
  logic             restart;
  logic [WIDTH-1:0] mod_val;
  logic             mod_load;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             tick;
  logic             mod_pending;
  logic             mod_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  modulo_ticker #(.WIDTH(WIDTH), .MOD_DEFAULT(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .dir         (dir),
    .restart     (restart),
    .mod_val     (mod_val),
    .mod_load    (mod_load),
    .count       (count),
    .zero        (zero),
    .tick        (tick),
    .mod_pending (mod_pending),
    .mod_err     (mod_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int c, input logic t,
                              input logic p, input logic e);
    check({tag, " count"},   32'(count),       32'(c));
    check({tag, " tick"},    32'(tick),        32'(t));
    check({tag, " pending"}, 32'(mod_pending), 32'(p));
    check({tag, " err"},     32'(mod_err),     32'(e));
    check({tag, " zero"},    32'(zero),        32'(c == 0));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dir = 1'b0; restart = 1'b0;
    mod_val = '0; mod_load = 1'b0;
    step(); step();
    expect_state("reset", 0, 1'b0, 1'b0, 1'b0);

    // Free run with default modulus 32
    rst = 1'b1; en = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      expect_state($sformatf("t1 k%0d", k), k % 32, 1'(k % 32 == 0), 1'b0, 1'b0);
    end
    for (int c = 7; c <= 10; c++) begin
      step();
      expect_state($sformatf("t2 pre c%0d", c), c, 1'b0, 1'b0, 1'b0);
    end

    // Load 5 at count 10, applied at the next wrap
    mod_load = 1'b1; mod_val = 16'd5; step(); mod_load = 1'b0;
    expect_state("t2 load", 11, 1'b0, 1'b1, 1'b0);
    for (int c = 12; c <= 31; c++) begin
      step();
      expect_state($sformatf("t2 run c%0d", c), c, 1'b0, 1'b1, 1'b0);
    end
    step();
    expect_state("t2 wrap", 0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      expect_state($sformatf("t2 m5 k%0d", k), k % 5, 1'(k % 5 == 0), 1'b0, 1'b0);
    end

    // Down count with M=8, two loads before the wrap (last wins)
    dir = 1'b1; restart = 1'b1; mod_load = 1'b1; mod_val = 16'd8;
    step(); restart = 1'b0; mod_load = 1'b0;
    expect_state("t3 restart", 7, 1'b0, 1'b0, 1'b0);
    for (int c = 6; c >= 4; c--) begin
      step();
      expect_state($sformatf("t3 dn c%0d", c), c, 1'b0, 1'b0, 1'b0);
    end
    mod_load = 1'b1; mod_val = 16'd3; step();
    expect_state("t3 load3", 3, 1'b0, 1'b1, 1'b0);
    mod_val = 16'd4; step(); mod_load = 1'b0;
    expect_state("t3 load4", 2, 1'b0, 1'b1, 1'b0);
    step(); expect_state("t3 c1", 1, 1'b0, 1'b1, 1'b0);
    step(); expect_state("t3 c0", 0, 1'b0, 1'b1, 1'b0);
    step(); expect_state("t3 wrap", 3, 1'b1, 1'b0, 1'b0);
    step(); expect_state("t3 m4 c2", 2, 1'b0, 1'b0, 1'b0);
    step(); expect_state("t3 m4 c1", 1, 1'b0, 1'b0, 1'b0);
    step(); expect_state("t3 m4 c0", 0, 1'b0, 1'b0, 1'b0);
    step(); expect_state("t3 m4 wrap", 3, 1'b1, 1'b0, 1'b0);

    // Restart at count 20 with pending 12
    dir = 1'b0; restart = 1'b1; mod_load = 1'b1; mod_val = 16'd32;
    step(); restart = 1'b0; mod_load = 1'b0;
    expect_state("t4 m32", 0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      step();
      expect_state($sformatf("t4 c%0d", c), c, 1'b0, 1'b0, 1'b0);
    end
    mod_load = 1'b1; mod_val = 16'd12; step(); mod_load = 1'b0;
    expect_state("t4 load12", 6, 1'b0, 1'b1, 1'b0);
    for (int c = 7; c <= 20; c++) begin
      step();
      expect_state($sformatf("t4 run c%0d", c), c, 1'b0, 1'b1, 1'b0);
    end
    restart = 1'b1; step(); restart = 1'b0;
    expect_state("t4 restart", 0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      step();
      expect_state($sformatf("t4 m12 c%0d", c), c, 1'b0, 1'b0, 1'b0);
    end
    step(); expect_state("t4 m12 wrap", 0, 1'b1, 1'b0, 1'b0);

    // Zero load rejected; then M=1 loaded at a wrap
    mod_load = 1'b1; mod_val = 16'd0; step(); mod_load = 1'b0;
    expect_state("t5 err", 1, 1'b0, 1'b0, 1'b1);
    step(); expect_state("t5 err clr", 2, 1'b0, 1'b0, 1'b0);
    for (int c = 3; c <= 11; c++) begin
      step();
      expect_state($sformatf("t5 c%0d", c), c, 1'b0, 1'b0, 1'b0);
    end
    mod_load = 1'b1; mod_val = 16'd1; step(); mod_load = 1'b0;
    expect_state("t5 m1 apply", 0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      expect_state($sformatf("t5 m1 k%0d", k), 0, 1'b1, 1'b0, 1'b0);
    end
    en = 1'b0; step();
    expect_state("t5 m1 hold", 0, 1'b0, 1'b0, 1'b0);

    // Reset mid-count with a pending load
    en = 1'b1; restart = 1'b1; mod_load = 1'b1; mod_val = 16'd32;
    step(); restart = 1'b0; mod_load = 1'b0;
    expect_state("t6 restart", 0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      step();
      expect_state($sformatf("t6 c%0d", c), c, 1'b0, 1'b0, 1'b0);
    end
    mod_load = 1'b1; mod_val = 16'd7; step(); mod_load = 1'b0;
    expect_state("t6 load7", 6, 1'b0, 1'b1, 1'b0);
    rst = 1'b0; step();
    expect_state("t6 rst", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; en = 1'b0; step();
    expect_state("t6 hold", 0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      expect_state($sformatf("t6 m32 c%0d", c), c, 1'b0, 1'b0, 1'b0);
    end
    step(); expect_state("t6 m32 wrap", 0, 1'b1, 1'b0, 1'b0);

    // Direction reversal mid-count
    for (int c = 1; c <= 3; c++) begin
      step();
      expect_state($sformatf("dirchg up c%0d", c), c, 1'b0, 1'b0, 1'b0);
    end
    dir = 1'b1;
    for (int c = 2; c >= 0; c--) begin
      step();
      expect_state($sformatf("dirchg dn c%0d", c), c, 1'b0, 1'b0, 1'b0);
    end
    step(); expect_state("dirchg wrap", 31, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
